bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Arbitrates the shared serial system bus between two masters, each a MasterOut instance.
- Takes each master's approval_request and returns approval_grant and busy to it.
- Latches the winning master's slave_select and drives the one-hot slave enable and the master-side mux select for the bus datapath.
- Enforces round-robin fairness, and a timeout so a hung master cannot hold the bus.

Parameters:
- TIMEOUT_CYCLES, 256: maximum cycles a grant may be held before forced release; legal range 2..4095.
- CNT_WIDTH, 12: width of the hold counter; must satisfy 2^CNT_WIDTH > TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- approval_request  input  2  bit i = request from master i.
- tx_done  input  2  bit i = master i reports transaction complete; single-cycle pulse.
- m0_slave_select  input  2  slave target of master 0.
- m1_slave_select  input  2  slave target of master 1.
- approval_grant  output  2  one-hot or zero; bit i = master i owns bus.
- busy  output  1  bus owned or in turnaround; routed to both masters.
- bus_owner  output  1  mux select for master-side datapath; 0 = master 0, 1 = master 1.
- slave_enable  output  4  one-hot enable of target slave; zero when no owner.
- timeout  output  1  one-cycle pulse on forced release.

Behaviour:
- All outputs are registered. Reset is synchronous and active-high.
- On reset: state=IDLE, approval_grant=0, busy=0, bus_owner=0, slave_enable=0, timeout=0, hold counter=0, rr_ptr=0 (master 0 favoured first).
- Reset mid-transaction drops the grant on the same edge; no RELEASE cycle follows.

IDLE state:
- busy=0, approval_grant=0, slave_enable=0.
- If any request bit is high at edge k, go to OWNED; grant is visible after edge k, a 1-cycle latency.
- Winner selection: only one request high gives that master. Both high gives master rr_ptr.
- At the grant edge, bus_owner is set to the winner. slave_enable is set to one-hot of the winner's slave_select, sampled at that same edge; it is held constant for the whole tenure.
- Counter is cleared to 0.

OWNED state:
- busy=1; approval_grant[bus_owner]=1; the other grant bit is 0.
- Counter increments by 1 per cycle and saturates; it never wraps.
- Exit conditions, checked in this priority order:
  - (a) tx_done[bus_owner]=1: normal completion.
  - (b) approval_request[bus_owner]=0: abort.
  - (c) counter == TIMEOUT_CYCLES-1: timeout=1 for exactly one cycle, coincident with the first RELEASE cycle.
- On any exit: go to RELEASE, approval_grant=0, slave_enable=0, rr_ptr = ~bus_owner.
- tx_done or request from the non-owner is ignored while OWNED.
- Slave-select changes by the owner after the grant are ignored.

RELEASE state:
- Exactly 1 turnaround cycle: busy=1, all grants 0.
- Then IDLE unconditionally. Back-to-back grants are therefore separated by at least 2 cycles with grant low.

Simultaneous and boundary cases:
- tx_done and timeout condition in the same cycle: treated as a normal completion, so timeout stays 0.
- tx_done arriving in IDLE or RELEASE: ignored.
- A requester that keeps its request high after release: re-arbitrated in IDLE against rr_ptr, so the other master wins if it is also requesting.
- bus_owner holds its last value when the bus is idle.

Invariants:
- approval_grant is never 2'b11.
- slave_enable is nonzero only while approval_grant is nonzero.

Test Plan:
- Single request: reset 3 cycles; approval_request=01, m0_slave_select=11. Expect: grant=01 and slave_enable=1000 one cycle later, busy=1. Pulse tx_done=01 after 15 cycles. Expect: grant=00 next edge, busy=1 for 1 cycle, then 0.
- Contention and fairness: approval_request=11 from reset, rr_ptr=0. Expect master 0 granted first. After its tx_done, with both still requesting, expect grant=10 exactly 2 cycles after the release edge, bus_owner=1.
- Timeout: TIMEOUT_CYCLES=8; master 1 requests with m1_slave_select=10 and never asserts tx_done. Expect grant=10 for exactly 8 cycles, slave_enable=0100, then timeout pulse of 1 cycle, grant=00, next grant to master 0 if it is requesting.
- Abort and stray done: master 0 granted; master 1 pulses tx_done=10 (expect no effect); master 0 drops its request. Expect release on the next edge, timeout=0.
- Reset mid-transaction: master 1 owns the bus, slave_enable=0001; assert reset for 1 cycle. Expect all outputs 0 after that edge with no RELEASE cycle, and master 0 winning the first contention after reset.
- Done/timeout collision: TIMEOUT_CYCLES=4; tx_done asserted on counter==3. Expect normal release with timeout held at 0.

Source files
------------

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter for the shared serial bus, with hold timeout.
// state   | meaning
// IDLE    | bus free, arbitrating pending requests
// OWNED   | one master holds the grant, hold counter running
// RELEASE | single turnaround cycle, no grant, busy still high
module bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_WIDTH      = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] approval_request,
    input  logic [1:0] tx_done,
    input  logic [1:0] m0_slave_select,
    input  logic [1:0] m1_slave_select,
    output logic [1:0] approval_grant,
    output logic       busy,
    output logic       bus_owner,
    output logic [3:0] slave_enable,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWNED   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t               state_q, state_d;
    logic [1:0]           grant_q, grant_d;
    logic                 busy_q, busy_d;
    logic                 owner_q, owner_d;
    logic [3:0]           slave_en_q, slave_en_d;
    logic                 timeout_q, timeout_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 rr_ptr_q, rr_ptr_d;

    logic       winner;
    logic [1:0] winner_sel;
    logic       owner_done;
    logic       owner_req;
    logic       hold_expired;

    always_comb begin
        winner       = (approval_request == 2'b11) ? rr_ptr_q : approval_request[1];
        winner_sel   = winner ? m1_slave_select : m0_slave_select;
        owner_done   = tx_done[owner_q];
        owner_req    = approval_request[owner_q];
        hold_expired = (cnt_q == CNT_LAST);
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        busy_d     = busy_q;
        owner_d    = owner_q;
        slave_en_d = slave_en_q;
        timeout_d  = 1'b0;
        cnt_d      = cnt_q;
        rr_ptr_d   = rr_ptr_q;

        case (state_q)
            IDLE: begin
                grant_d    = 2'b00;
                busy_d     = 1'b0;
                slave_en_d = 4'b0000;
                if (|approval_request) begin
                    state_d    = OWNED;
                    owner_d    = winner;
                    grant_d    = {winner, ~winner};
                    busy_d     = 1'b1;
                    slave_en_d = 4'b0001 << winner_sel;
                    cnt_d      = '0;
                end
            end
            OWNED: begin
                if (owner_done || !owner_req || hold_expired) begin
                    state_d    = RELEASE;
                    grant_d    = 2'b00;
                    slave_en_d = 4'b0000;
                    busy_d     = 1'b1;
                    rr_ptr_d   = ~owner_q;
                    // completion and abort both take precedence over the timeout
                    timeout_d  = !owner_done && owner_req && hold_expired;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RELEASE: begin
                state_d    = IDLE;
                grant_d    = 2'b00;
                slave_en_d = 4'b0000;
                busy_d     = 1'b0;
            end
            default: begin
                state_d    = IDLE;
                grant_d    = 2'b00;
                slave_en_d = 4'b0000;
                busy_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_q    <= 2'b00;
            busy_q     <= 1'b0;
            owner_q    <= 1'b0;
            slave_en_q <= 4'b0000;
            timeout_q  <= 1'b0;
            cnt_q      <= '0;
            rr_ptr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            busy_q     <= busy_d;
            owner_q    <= owner_d;
            slave_en_q <= slave_en_d;
            timeout_q  <= timeout_d;
            cnt_q      <= cnt_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign approval_grant = grant_q;
    assign busy           = busy_q;
    assign bus_owner      = owner_q;
    assign slave_enable   = slave_en_q;
    assign timeout        = timeout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter; three instances share stimulus with TIMEOUT_CYCLES of 256, 8 and 4.
module tb_bus_arbiter;

    logic       clk;
    logic       rst;
    logic [1:0] req;
    logic [1:0] done;
    logic [1:0] s0;
    logic [1:0] s1;

    logic [1:0] gnt_a, gnt_b, gnt_c;
    logic       busy_a, busy_b, busy_c;
    logic       own_a, own_b, own_c;
    logic [3:0] sen_a, sen_b, sen_c;
    logic       to_a, to_b, to_c;

    int pass_cnt  = 0;
    int total_cnt = 0;

    bus_arbiter #(.TIMEOUT_CYCLES(256), .CNT_WIDTH(12)) dut (
        .clk(clk), .reset(rst), .approval_request(req), .tx_done(done),
        .m0_slave_select(s0), .m1_slave_select(s1),
        .approval_grant(gnt_a), .busy(busy_a), .bus_owner(own_a),
        .slave_enable(sen_a), .timeout(to_a)
    );

    bus_arbiter #(.TIMEOUT_CYCLES(8), .CNT_WIDTH(4)) dut8 (
        .clk(clk), .reset(rst), .approval_request(req), .tx_done(done),
        .m0_slave_select(s0), .m1_slave_select(s1),
        .approval_grant(gnt_b), .busy(busy_b), .bus_owner(own_b),
        .slave_enable(sen_b), .timeout(to_b)
    );

    bus_arbiter #(.TIMEOUT_CYCLES(4), .CNT_WIDTH(3)) dut4 (
        .clk(clk), .reset(rst), .approval_request(req), .tx_done(done),
        .m0_slave_select(s0), .m1_slave_select(s1),
        .approval_grant(gnt_c), .busy(busy_c), .bus_owner(own_c),
        .slave_enable(sen_c), .timeout(to_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = 2'b00;
        done = 2'b00;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 2'b00; done = 2'b00; s0 = 2'b00; s1 = 2'b00;
        repeat (3) tick();
        total_cnt++; if (gnt_a !== 2'b00) $display("FAIL reset_grant got %b want 00", gnt_a); else pass_cnt++;
        total_cnt++; if (busy_a !== 1'b0) $display("FAIL reset_busy got %b want 0", busy_a); else pass_cnt++;
        total_cnt++; if (own_a !== 1'b0) $display("FAIL reset_owner got %b want 0", own_a); else pass_cnt++;
        total_cnt++; if (sen_a !== 4'b0000) $display("FAIL reset_slave_en got %b want 0000", sen_a); else pass_cnt++;
        total_cnt++; if (to_a !== 1'b0) $display("FAIL reset_timeout got %b want 0", to_a); else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        req = 2'b01; s0 = 2'b11;
        tick();
        total_cnt++; if (gnt_a !== 2'b01) $display("FAIL single_grant got %b want 01", gnt_a); else pass_cnt++;
        total_cnt++; if (sen_a !== 4'b1000) $display("FAIL single_slave_en got %b want 1000", sen_a); else pass_cnt++;
        total_cnt++; if (busy_a !== 1'b1) $display("FAIL single_busy got %b want 1", busy_a); else pass_cnt++;
        s0 = 2'b00;
        repeat (14) tick();
        total_cnt++; if (gnt_a !== 2'b01) $display("FAIL single_hold got %b want 01", gnt_a); else pass_cnt++;
        total_cnt++; if (sen_a !== 4'b1000) $display("FAIL single_sel_locked got %b want 1000", sen_a); else pass_cnt++;
        done = 2'b01;
        tick();
        done = 2'b00; req = 2'b00;
        total_cnt++; if (gnt_a !== 2'b00) $display("FAIL single_release_grant got %b want 00", gnt_a); else pass_cnt++;
        total_cnt++; if (busy_a !== 1'b1) $display("FAIL single_turnaround_busy got %b want 1", busy_a); else pass_cnt++;
        total_cnt++; if (sen_a !== 4'b0000) $display("FAIL single_release_sen got %b want 0000", sen_a); else pass_cnt++;
        tick();
        total_cnt++; if (busy_a !== 1'b0) $display("FAIL single_idle_busy got %b want 0", busy_a); else pass_cnt++;
        total_cnt++; if (own_a !== 1'b0) $display("FAIL single_owner_hold got %b want 0", own_a); else pass_cnt++;
    endtask

    task automatic test_fairness();
        do_reset();
        req = 2'b11; s0 = 2'b01; s1 = 2'b10;
        tick();
        total_cnt++; if (gnt_a !== 2'b01) $display("FAIL fair_first_grant got %b want 01", gnt_a); else pass_cnt++;
        total_cnt++; if (sen_a !== 4'b0010) $display("FAIL fair_first_sen got %b want 0010", sen_a); else pass_cnt++;
        done = 2'b11;
        tick();
        done = 2'b00;
        total_cnt++; if (gnt_a !== 2'b00) $display("FAIL fair_release got %b want 00", gnt_a); else pass_cnt++;
        tick();
        total_cnt++; if (gnt_a !== 2'b00 || busy_a !== 1'b0) $display("FAIL fair_idle_gap got grant %b busy %b want 00 0", gnt_a, busy_a); else pass_cnt++;
        tick();
        total_cnt++; if (gnt_a !== 2'b10) $display("FAIL fair_second_grant got %b want 10", gnt_a); else pass_cnt++;
        total_cnt++; if (own_a !== 1'b1) $display("FAIL fair_second_owner got %b want 1", own_a); else pass_cnt++;
        total_cnt++; if (sen_a !== 4'b0100) $display("FAIL fair_second_sen got %b want 0100", sen_a); else pass_cnt++;
        done = 2'b10;
        tick();
        done = 2'b00;
        repeat (2) tick();
        total_cnt++; if (gnt_a !== 2'b01) $display("FAIL fair_back_to_m0 got %b want 01", gnt_a); else pass_cnt++;
        total_cnt++; if (own_a !== 1'b0) $display("FAIL fair_back_owner got %b want 0", own_a); else pass_cnt++;
    endtask

    task automatic test_timeout();
        int hold;
        do_reset();
        req = 2'b10; s0 = 2'b00; s1 = 2'b10;
        tick();
        total_cnt++; if (sen_b !== 4'b0100) $display("FAIL to_slave_en got %b want 0100", sen_b); else pass_cnt++;
        req = 2'b11;
        hold = (gnt_b === 2'b10) ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (gnt_b !== 2'b10) break;
            hold++;
        end
        total_cnt++; if (hold != 8) $display("FAIL to_hold_cycles got %0d want 8", hold); else pass_cnt++;
        total_cnt++; if (to_b !== 1'b1) $display("FAIL to_pulse got %b want 1", to_b); else pass_cnt++;
        total_cnt++; if (gnt_b !== 2'b00 || busy_b !== 1'b1) $display("FAIL to_release got grant %b busy %b want 00 1", gnt_b, busy_b); else pass_cnt++;
        tick();
        total_cnt++; if (to_b !== 1'b0) $display("FAIL to_pulse_width got %b want 0", to_b); else pass_cnt++;
        tick();
        total_cnt++; if (gnt_b !== 2'b01) $display("FAIL to_next_owner got %b want 01", gnt_b); else pass_cnt++;
    endtask

    task automatic test_abort();
        do_reset();
        req = 2'b01; s0 = 2'b00;
        tick();
        total_cnt++; if (gnt_a !== 2'b01) $display("FAIL abort_grant got %b want 01", gnt_a); else pass_cnt++;
        done = 2'b10; req = 2'b11;
        tick();
        done = 2'b00;
        total_cnt++; if (gnt_a !== 2'b01 || busy_a !== 1'b1) $display("FAIL abort_stray_done got grant %b busy %b want 01 1", gnt_a, busy_a); else pass_cnt++;
        req = 2'b00;
        tick();
        total_cnt++; if (gnt_a !== 2'b00 || busy_a !== 1'b1) $display("FAIL abort_release got grant %b busy %b want 00 1", gnt_a, busy_a); else pass_cnt++;
        total_cnt++; if (to_a !== 1'b0) $display("FAIL abort_timeout got %b want 0", to_a); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 2'b10; s1 = 2'b00;
        tick();
        total_cnt++; if (sen_a !== 4'b0001 || own_a !== 1'b1) $display("FAIL rmid_setup got sen %b owner %b want 0001 1", sen_a, own_a); else pass_cnt++;
        tick();
        rst = 1'b1; req = 2'b11;
        tick();
        rst = 1'b0;
        total_cnt++; if ({gnt_a, busy_a, own_a, sen_a, to_a} !== 9'b0) $display("FAIL rmid_outputs got %b want 000000000", {gnt_a, busy_a, own_a, sen_a, to_a}); else pass_cnt++;
        tick();
        total_cnt++; if (gnt_a !== 2'b01) $display("FAIL rmid_first_contention got %b want 01", gnt_a); else pass_cnt++;
    endtask

    task automatic test_collision();
        do_reset();
        req = 2'b01; s0 = 2'b01;
        repeat (4) tick();
        total_cnt++; if (gnt_c !== 2'b01) $display("FAIL coll_hold got %b want 01", gnt_c); else pass_cnt++;
        done = 2'b01;
        tick();
        done = 2'b00; req = 2'b00;
        total_cnt++; if (gnt_c !== 2'b00 || busy_c !== 1'b1) $display("FAIL coll_release got grant %b busy %b want 00 1", gnt_c, busy_c); else pass_cnt++;
        total_cnt++; if (to_c !== 1'b0) $display("FAIL coll_timeout got %b want 0", to_c); else pass_cnt++;
        tick();
        total_cnt++; if (to_c !== 1'b0 || busy_c !== 1'b0) $display("FAIL coll_idle got to %b busy %b want 0 0", to_c, busy_c); else pass_cnt++;
    endtask

    initial begin
        rst = 1'b1; req = 2'b00; done = 2'b00; s0 = 2'b00; s1 = 2'b00;
        test_reset();
        test_single();
        test_fairness();
        test_timeout();
        test_abort();
        test_reset_mid();
        test_collision();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
